// File: rtl/myo_pwm_pkg.sv
// Shared types and helpers for the H-bridge PWM generator.
// Holds the bridge state encoding, per-leg drive modes and the duty magnitude helper.
package myo_pwm_pkg;

    localparam int unsigned DUTY_W = 16;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_FWD,
        ST_REV,
        ST_SWITCH
    } state_t;

    typedef enum logic [1:0] {
        LEG_OFF,
        LEG_LOW,
        LEG_MOD
    } leg_mode_t;

    // Magnitude of a signed 16-bit value; -32768 saturates to 32767.
    function automatic logic [DUTY_W-1:0] abs_sat16(input logic signed [15:0] value);
        if (value == 16'sh8000) begin
            return 16'h7fff;
        end else if (value[15]) begin
            return $unsigned(-value);
        end else begin
            return $unsigned(value);
        end
    endfunction

endpackage

// File: rtl/hbridge_pwm_generator_leg.sv
// One half-bridge leg: registered high/low gate drives derived from the shared
// period counter, with dead-time inserted on both sides of the high pulse.
import myo_pwm_pkg::*;

module hbridge_leg #(
    parameter int unsigned DEADTIME = 25
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DUTY_W-1:0] counter,
    input  logic [DUTY_W-1:0] duty,
    input  leg_mode_t         mode,
    output logic              hi,
    output logic              lo
);

    localparam logic [DUTY_W:0] DT = (DUTY_W+1)'(DEADTIME);

    logic [DUTY_W:0] count_ext;
    logic [DUTY_W:0] lo_start;

    always_comb begin
        count_ext = {1'b0, counter};
        lo_start  = {1'b0, duty} + DT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi <= 1'b0;
            lo <= 1'b0;
        end else begin
            case (mode)
                LEG_LOW: begin
                    hi <= 1'b0;
                    lo <= 1'b1;
                end
                LEG_MOD: begin
                    if (duty == '0) begin
                        hi <= 1'b0;
                        lo <= 1'b1;
                    end else begin
                        // High and low windows are disjoint by DT, so hi&lo never overlap.
                        hi <= (count_ext >= DT) && (counter < duty);
                        lo <= (count_ext >= lo_start);
                    end
                end
                default: begin
                    hi <= 1'b0;
                    lo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hbridge_pwm_generator.sv
// Sign-magnitude H-bridge PWM generator: samples the PID output on its valid strobe,
// applies it at period boundaries, and sequences direction reversals through an all-off period.
import myo_pwm_pkg::*;

module hbridge_pwm_generator #(
    parameter int unsigned PERIOD   = 2500,
    parameter int unsigned DEADTIME = 25
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic signed [15:0]       pwm_ref,
    input  logic                     update_controller,
    output logic                     hi_a,
    output logic                     lo_a,
    output logic                     hi_b,
    output logic                     lo_b,
    output logic                     period_start,
    output logic                     direction,
    output logic [DUTY_W-1:0]        duty_active
);

    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(PERIOD - DEADTIME);
    localparam logic [DUTY_W-1:0] DT   = DUTY_W'(DEADTIME);

    logic [DUTY_W-1:0]  counter;
    logic               boundary;
    logic               update_prev;
    logic signed [15:0] pending;
    logic [DUTY_W-1:0]  mag;
    logic [DUTY_W-1:0]  clamped;
    logic [DUTY_W-1:0]  next_duty;
    logic               req_dir;
    state_t             state;
    leg_mode_t          mode_a;
    leg_mode_t          mode_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter      <= '0;
            period_start <= 1'b0;
        end else begin
            counter      <= boundary ? '0 : counter + 1'b1;
            period_start <= (counter == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            update_prev <= 1'b0;
            pending     <= '0;
        end else begin
            update_prev <= update_controller;
            if (update_controller && !update_prev) begin
                pending <= pwm_ref;
            end
        end
    end

    always_comb begin
        boundary  = (counter == LAST);
        mag       = abs_sat16(pending);
        clamped   = (mag > DMAX) ? DMAX : mag;
        next_duty = (clamped <= DT) ? '0 : clamped;
        req_dir   = (pending == '0) ? direction : pending[15];
    end

    // Disable wins over the boundary; direction always tracks the request at a live boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_OFF;
            direction   <= 1'b0;
            duty_active <= '0;
        end else begin
            if (boundary) begin
                duty_active <= next_duty;
            end
            if (!enable) begin
                state <= ST_OFF;
            end else if (boundary) begin
                direction <= req_dir;
                case (state)
                    ST_OFF:    state <= req_dir ? ST_REV : ST_FWD;
                    ST_FWD:    state <= req_dir ? ST_SWITCH : ST_FWD;
                    ST_REV:    state <= req_dir ? ST_REV : ST_SWITCH;
                    ST_SWITCH: state <= req_dir ? ST_REV : ST_FWD;
                    default:   state <= ST_OFF;
                endcase
            end
        end
    end

    always_comb begin
        mode_a = LEG_OFF;
        mode_b = LEG_OFF;
        if (enable) begin
            case (state)
                ST_FWD: begin
                    mode_a = LEG_MOD;
                    mode_b = LEG_LOW;
                end
                ST_REV: begin
                    mode_a = LEG_LOW;
                    mode_b = LEG_MOD;
                end
                default: begin
                    mode_a = LEG_OFF;
                    mode_b = LEG_OFF;
                end
            endcase
        end
    end

    hbridge_leg #(.DEADTIME(DEADTIME)) u_leg_a (
        .clock   (clock),
        .reset_n (reset_n),
        .counter (counter),
        .duty    (duty_active),
        .mode    (mode_a),
        .hi      (hi_a),
        .lo      (lo_a)
    );

    hbridge_leg #(.DEADTIME(DEADTIME)) u_leg_b (
        .clock   (clock),
        .reset_n (reset_n),
        .counter (counter),
        .duty    (duty_active),
        .mode    (mode_b),
        .hi      (hi_b),
        .lo      (lo_b)
    );

endmodule

// File: doc/hbridge_pwm_generator.md
Name: hbridge_pwm_generator

Overview:
- Downstream consumer of the PID controller's signed 16-bit pwmRef.
- Converts the latest PID output into sign-magnitude, period-synchronous PWM gate signals for a full H-bridge (legs A and B), with complementary dead-time and a safe direction-reversal sequence.
- Emits a period-start strobe that can drive the PID controller's update_controller input, so the control loop runs in lockstep with the PWM frame.

Parameters:
- PERIOD, 2500, clocks per PWM period (20 kHz at 50 MHz); 16 < PERIOD <= 65535.
- DEADTIME, 25, clocks with both gates of a leg off around every complementary edge; 1 <= DEADTIME < PERIOD/4.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  gate enable; low forces all gates off
- pwm_ref  in  16  signed duty request, same scale as PID output
- update_controller  in  1  rising edge samples pwm_ref (PID result-valid strobe)
- hi_a, lo_a, hi_b, lo_b  out  1 each  gate drives, registered
- period_start  out  1  one-clock pulse when counter==0
- direction  out  1  1=reverse, registered
- duty_active  out  16  unsigned duty in use this period

Behaviour:
- Reset: counter=0, state=OFF, pending=0, duty_active=0, direction=0, all gates=0, period_start=0.
- Counter: 0..PERIOD-1, wraps to 0. period_start is registered and high exactly on the cycle after counter==0.
- Sampling: edge-detect update_controller (previous-value register). On a rising edge, pending <= pwm_ref. Edges closer than one period: last one wins.
- Magnitude rules, applied at load time:
  - mag = |pending|, with -32768 mapped to 32767.
  - Clamp mag to DMAX = PERIOD-DEADTIME.
  - mag <= DEADTIME gives duty 0.
  - Sign bit gives the requested direction; pending==0 requests the current direction with duty 0.
- Shadow load: only on the cycle where counter==PERIOD-1 do duty_active and the state transition take effect. There are no mid-period duty changes.
- States:
  - OFF: all gates 0.
  - FWD: leg B lo_b=1, hi_b=0; leg A modulated.
  - REV: mirror of FWD (leg A lo_a=1, leg B modulated).
  - SWITCH: all gates 0 for one full period; then enters the requested direction.
- Transitions, evaluated at the boundary:
  - OFF -> FWD/REV when enable=1.
  - FWD <-> REV always goes through SWITCH, never directly.
  - Same direction: stay in the current state.
  - A sign change during SWITCH retargets the exit state.
- Modulated leg, from counter c and duty d:
  - hi = (c >= DEADTIME) && (c < d).
  - lo = (c >= d+DEADTIME).
  - d==0: hi=0, lo=1 for the whole period.
- Gates register from c with 1-clock latency. hi and lo of one leg are never 1 simultaneously, in any state or on any cycle.
- enable low: on the next clock, state=OFF and all gates=0, regardless of counter. pending is retained. Re-enable takes effect at the next boundary.
- Reset asserted mid-period: gates drop asynchronously to 0.
- direction updates at the boundary together with the state.

Decomposition:
- Shared package myo_pwm_pkg:
  - state enum (OFF, FWD, REV, SWITCH)
  - duty width constant (16)
  - function abs_sat16 (sign-magnitude with -32768 saturation)
- Sub-module hbridge_leg: takes counter, duty, mode (off / low-on / modulate) and DEADTIME; outputs registered hi/lo. Instantiated twice.
- Top level holds the counter, edge detect, pending and shadow registers, and the FSM.

Test Plan (bench uses PERIOD=100, DEADTIME=5):
- Reset release, enable=1, pwm_ref=0 -> period_start every 100 clocks. After the first boundary, state FWD, lo_a=lo_b=1, hi_a=hi_b=0.
- pwm_ref=+40 with update edge mid-period -> the next period shows hi_a high for c=5..39 (35 clocks) and lo_a high for c=45..99. Before that boundary there is no change. duty_active=40.
- pwm_ref=+40 then -40 -> one full period with all gates 0, then REV with hi_b=35 clocks and lo_a=1. A checker flags any hi/lo overlap per leg across the whole run.
- Saturation cases:
  - pwm_ref=+32767 gives duty 95: hi_a for c=5..94, lo_a never.
  - pwm_ref=-32768 gives duty 95 in REV.
  - pwm_ref=+3 gives duty 0.
- Two update edges 10 clocks apart (+20 then +60) within one period -> the next period uses duty 60.
- enable dropped at c=50 -> all gates 0 at c=51. Re-enable at c=70 -> gates resume at the next boundary with the retained duty. Async reset_n low at c=30 -> gates 0 immediately.
